// File: rtl/csr_access_responder.sv
// csr_access_responder: single-outstanding CSR access port for a small RV32 core.
// Each access is a read-swap: the response carries the pre-access CSR value,
// and a write takes effect at the accept edge. Hosts 64-bit mcycle and,
// when CSR_ACCESS_RESPONDER_INSTRET_EN is defined, a 64-bit minstret counter.
module csr_access_responder #(
  parameter logic [31:0] MISA_VALUE      = 32'h40001105,
  parameter bit          ERR_ON_RO_WRITE = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        retire
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state_reg;
  state_t state_next;

  logic [31:0] mcounteren_reg;
  logic        inhibit_cy_reg;
  logic        inhibit_ir;
  logic [31:0] mscratch_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic [31:0] mtval_reg;
  logic [31:0] dpc_reg;
  logic [63:0] mcycle_reg;

  logic        accept;
  logic        hit;
  logic        is_misa;
  logic        err;
  logic        wr_en;
  logic [31:0] rd_val;

  // The handshake is gated by reset so the port looks busy while held in reset.
  assign req_ready  = (state_reg == IDLE) && reset_n;
  assign resp_valid = (state_reg == RESP);
  assign accept     = req_valid && req_ready;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next state: one request in flight, released by the response handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef CSR_ACCESS_RESPONDER_INSTRET_EN
  logic        inhibit_ir_reg;
  logic [63:0] minstret_reg;
  assign inhibit_ir = inhibit_ir_reg;
`else
  logic unused_retire;
  assign inhibit_ir    = 1'b0;
  assign unused_retire = retire;
`endif

  // Address decode and the pre-access read value.
  always_comb begin
    hit    = 1'b1;
    rd_val = 32'd0;
    case (req_addr)
      12'h301: rd_val = MISA_VALUE;
      12'h306: rd_val = mcounteren_reg;
      12'h320: rd_val = {29'd0, inhibit_ir, 1'b0, inhibit_cy_reg};
      12'h340: rd_val = mscratch_reg;
      12'h341: rd_val = mepc_reg;
      12'h342: rd_val = mcause_reg;
      12'h343: rd_val = mtval_reg;
      12'h7B1: rd_val = dpc_reg;
      12'hB00: rd_val = mcycle_reg[31:0];
      12'hB80: rd_val = mcycle_reg[63:32];
`ifdef CSR_ACCESS_RESPONDER_INSTRET_EN
      12'hB02: rd_val = minstret_reg[31:0];
      12'hB82: rd_val = minstret_reg[63:32];
`endif
      default: hit = 1'b0;
    endcase
  end

  assign is_misa = (req_addr == 12'h301);
  assign err     = !hit || (is_misa && req_write && ERR_ON_RO_WRITE);
  assign wr_en   = accept && req_write && hit && !is_misa;

  // Capture the response at accept; it is held until the handshake completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_rdata <= err ? 32'd0 : rd_val;
      resp_err   <= err;
    end
  end

  // Plain read/write CSRs; pc-type registers keep bit 0 clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcounteren_reg <= 32'd0;
      inhibit_cy_reg <= 1'b0;
      mscratch_reg   <= 32'd0;
      mepc_reg       <= 32'd0;
      mcause_reg     <= 32'd0;
      mtval_reg      <= 32'd0;
      dpc_reg        <= 32'd0;
    end else if (wr_en) begin
      case (req_addr)
        12'h306: mcounteren_reg <= req_wdata;
        12'h320: inhibit_cy_reg <= req_wdata[0];
        12'h340: mscratch_reg   <= req_wdata;
        12'h341: mepc_reg       <= {req_wdata[31:1], 1'b0};
        12'h342: mcause_reg     <= req_wdata;
        12'h343: mtval_reg      <= req_wdata;
        12'h7B1: dpc_reg        <= {req_wdata[31:1], 1'b0};
        default: ;
      endcase
    end
  end

  // mcycle: a write to either half wins over that cycle's increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                              mcycle_reg <= 64'd0;
    else if (wr_en && req_addr == 12'hB00)     mcycle_reg[31:0]  <= req_wdata;
    else if (wr_en && req_addr == 12'hB80)     mcycle_reg[63:32] <= req_wdata;
    else if (!inhibit_cy_reg)                  mcycle_reg <= mcycle_reg + 64'd1;
  end

`ifdef CSR_ACCESS_RESPONDER_INSTRET_EN
  // minstret and its inhibit bit; same write-over-increment priority as mcycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inhibit_ir_reg <= 1'b0;
      minstret_reg   <= 64'd0;
    end else begin
      if (wr_en && req_addr == 12'h320) inhibit_ir_reg <= req_wdata[2];
      if (wr_en && req_addr == 12'hB02)      minstret_reg[31:0]  <= req_wdata;
      else if (wr_en && req_addr == 12'hB82) minstret_reg[63:32] <= req_wdata;
      else if (retire && !inhibit_ir_reg)    minstret_reg <= minstret_reg + 64'd1;
    end
  end
`endif

endmodule

// File: doc/csr_access_responder.md
CSR_ACCESS_RESPONDER -- requirements
Module: csr_access_responder

Interface
REQ-001 SHALL have parameter MISA_VALUE, default 32'h40001105, read-only misa value (RV32IMAC).
REQ-002 SHALL have parameter ERR_ON_RO_WRITE, default 1, flag an error on writes to read-only CSRs.
REQ-003 SHALL have port clock input 1, the single clock; all state samples on its rising edge.
REQ-004 SHALL have port reset_n input 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port req_valid input 1, access request valid.
REQ-006 SHALL have port req_ready output 1, request accepted when high with req_valid.
REQ-007 SHALL have port req_write input 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_addr input 12, CSR address.
REQ-009 SHALL have port req_wdata input 32, write data.
REQ-010 SHALL have port resp_valid output 1, response valid.
REQ-011 SHALL have port resp_ready input 1, response consumed when high with resp_valid.
REQ-012 SHALL have port resp_rdata output 32, pre-access CSR value.
REQ-013 SHALL have port resp_err output 1, illegal address or illegal write.
REQ-014 SHALL have port retire input 1, one instruction retired this cycle.

Function
REQ-015 SHALL implement FSM IDLE -> RESP on accept; RESP -> IDLE on resp_valid && resp_ready; no other transitions.
REQ-016 SHALL drive req_ready = (state == IDLE); resp_valid = (state == RESP); one outstanding request only.
REQ-017 SHALL register resp_rdata/resp_err on the accept cycle, presenting them the following cycle (latency 1), held stable while resp_valid && !resp_ready.
REQ-018 SHALL decode: 0x301 misa (RO), 0x306 mcounteren, 0x320 mcountinhibit, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x7B1 dpc, 0xB00/0xB80 mcycle/mcycleh, 0xB02/0xB82 minstret/minstreth.
REQ-019 SHALL return rdata = value before the write (swap semantics); the write takes effect at the accept edge.
REQ-020 SHALL flag resp_err=1, rdata=0, with no state change, for an undecoded address, and for a write to misa when ERR_ON_RO_WRITE=1 (when 0, the write is silently ignored with err=0).
REQ-021 SHALL force mepc[0] and dpc[0] to 0; mcountinhibit stores only bits 0 (CY) and 2 (IR), others read 0.
REQ-022 SHALL increment the 64-bit mcycle every cycle while mcountinhibit[0]=0, carrying from the low half into the high half; 0xFFFFFFFF_FFFFFFFF wraps to 0.
REQ-023 SHALL increment minstret when retire=1 and mcountinhibit[2]=0, with identical width and carry rules.
REQ-024 SHALL, on a counter-half write in the same cycle as an increment, give the write priority: the written half takes wdata, the other half is unchanged, and the increment is dropped.
REQ-025 SHALL return the counter value sampled in the accept cycle, before that cycle's increment.

Reset
REQ-026 SHALL asynchronously clear on reset_n=0: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, and all CSRs and counters to 0; req_ready reads 0 while reset_n=0.
REQ-027 SHALL discard an in-flight response if reset asserts mid-transaction; no response is issued after reset release.

Configuration
REQ-028 SHALL compile the minstret/minstreth counter in only when macro CSR_ACCESS_RESPONDER_INSTRET_EN is defined.
REQ-029 SHALL, without the macro, have no minstret storage: 0xB02/0xB82 decode as undecoded (resp_err=1), retire is ignored, and mcountinhibit[2] reads 0.

Verification
REQ-030 SHALL be tested: write 0x340 wdata 0xDEADBEEF, then read 0x340 -> first resp rdata=0 err=0, second rdata=0xDEADBEEF.
REQ-031 SHALL be tested: read 0x123 -> resp_err=1, rdata=0; write 0x301 -> err=1, then read 0x301 -> 0x40001105.
REQ-032 SHALL be tested: write 0xB00=0xFFFFFFFF, 0xB80=0, mcountinhibit=0 -> mcycleh reads 1 after the carry; write mcountinhibit=1 -> two reads of 0xB00 are equal.
REQ-033 SHALL be tested: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stable; req_ready=0 throughout.
REQ-034 SHALL be tested: pulse retire 7 times with the macro defined -> minstret reads 7; without the macro -> 0xB02 err=1.
REQ-035 SHALL be tested: assert reset_n=0 while in RESP -> resp_valid=0 immediately; after release, read 0x340 -> rdata=0.
